// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// adpll_pkg: shared ADPLL constants and lock-detector state encodings.
// Revision: 1.0
// ============================================================================
package adpll_pkg;

  localparam int ADPLL_ERR_WIDTH      = 8;
  localparam int LD_LOCK_THRESH_DEF   = 4;
  localparam int LD_UNLOCK_THRESH_DEF = 12;
  localparam int LD_LOCK_CYCLES_DEF   = 64;
  localparam int LD_UNLOCK_CYCLES_DEF = 4;
  localparam int LD_CNT_WIDTH_DEF     = 8;

  typedef enum logic [1:0] {
    LD_UNLOCKED  = 2'd0,
    LD_ACQUIRING = 2'd1,
    LD_LOCKED    = 2'd2,
    LD_SLIPPING  = 2'd3
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/adpll_lock_detector_if.sv
`default_nettype none
// ============================================================================
// adpll_lock_detector_if: sample/control inputs and status outputs of the detector.
// Revision: 1.0
// ============================================================================
interface adpll_lock_detector_if
  import adpll_pkg::*;
#(
  parameter int ERR_WIDTH = ADPLL_ERR_WIDTH,
  parameter int CNT_WIDTH = LD_CNT_WIDTH_DEF
);
  logic                        enable_i;
  logic                        ref_clk_i;
  logic signed [ERR_WIDTH-1:0] error_i;
  logic                        clear_peak_i;
  logic                        locked_o;
  logic [1:0]                  state_o;
  logic                        lost_lock_o;
  logic [CNT_WIDTH-1:0]        lock_loss_cnt_o;
  logic [ERR_WIDTH-2:0]        err_peak_o;

  modport master (
    output enable_i, ref_clk_i, error_i, clear_peak_i,
    input  locked_o, state_o, lost_lock_o, lock_loss_cnt_o, err_peak_o
  );

  modport slave (
    input  enable_i, ref_clk_i, error_i, clear_peak_i,
    output locked_o, state_o, lost_lock_o, lock_loss_cnt_o, err_peak_o
  );
endinterface
`default_nettype wire

// File: rtl/adpll_lock_detector_ref_edge_strobe.sv
`default_nettype none
// ============================================================================
// ref_edge_strobe: 2-FF synchroniser plus rising-edge detector for ref_clk.
// Revision: 1.0
// ============================================================================
module ref_edge_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_clk,
  output logic strobe
);
  logic s1;
  logic s2;
  logic d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= ref_clk;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign strobe = s2 & ~d;
endmodule
`default_nettype wire

// File: rtl/adpll_lock_detector.sv
`default_nettype none
// ============================================================================
// adpll_lock_detector: two-threshold hysteretic lock detection on ADPLL error.
// Revision: 1.0
// ============================================================================
module adpll_lock_detector
  import adpll_pkg::*;
#(
  parameter int ERR_WIDTH     = ADPLL_ERR_WIDTH,
  parameter int LOCK_THRESH   = LD_LOCK_THRESH_DEF,
  parameter int UNLOCK_THRESH = LD_UNLOCK_THRESH_DEF,
  parameter int LOCK_CYCLES   = LD_LOCK_CYCLES_DEF,
  parameter int UNLOCK_CYCLES = LD_UNLOCK_CYCLES_DEF,
  parameter int CNT_WIDTH     = LD_CNT_WIDTH_DEF
) (
  input  logic                 fpga_clk_i,
  input  logic                 rst_pbn_i,
  adpll_lock_detector_if.slave lk
);
  localparam int MAG_W  = ERR_WIDTH - 1;
  localparam int GOOD_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam int BAD_W  = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES + 1) : 1;
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_CYCLES);
  localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(UNLOCK_CYCLES);
  localparam logic [MAG_W-1:0]  LOCK_T      = MAG_W'(LOCK_THRESH);
  localparam logic [MAG_W-1:0]  UNLOCK_T    = MAG_W'(UNLOCK_THRESH);

  logic                 strobe;
  logic [ERR_WIDTH-1:0] err_neg;
  logic [MAG_W-1:0]     err_abs;
  logic                 is_good;
  logic                 is_bad;
  logic                 sample;
  logic                 loss;

  ld_state_e            state, state_nx;
  logic [GOOD_W-1:0]    good, good_nx;
  logic [BAD_W-1:0]     bad, bad_nx;
  logic                 lost_q;
  logic [CNT_WIDTH-1:0] loss_cnt;
  logic [MAG_W-1:0]     peak;

  ref_edge_strobe u_strobe (
    .clk     (fpga_clk_i),
    .rst_n   (rst_pbn_i),
    .ref_clk (lk.ref_clk_i),
    .strobe  (strobe)
  );

  assign err_neg = -lk.error_i;

  // Only the most-negative code stays negative after negation; clamp it.
  always_comb begin
    if (!lk.error_i[ERR_WIDTH-1])
      err_abs = lk.error_i[MAG_W-1:0];
    else if (err_neg[ERR_WIDTH-1])
      err_abs = '1;
    else
      err_abs = err_neg[MAG_W-1:0];
  end

  assign is_good = (err_abs <= LOCK_T);
  assign is_bad  = (err_abs >  UNLOCK_T);
  assign sample  = strobe & lk.enable_i;

  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      state <= LD_UNLOCKED;
      good  <= '0;
      bad   <= '0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
      bad   <= bad_nx;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good;
    bad_nx   = bad;
    loss     = 1'b0;
    if (!lk.enable_i) begin
      state_nx = LD_UNLOCKED;
      good_nx  = '0;
      bad_nx   = '0;
    end else if (strobe) begin
      case (state)
        LD_UNLOCKED: begin
          if (is_good) begin
            if (LOCK_CYCLES == 1) begin
              state_nx = LD_LOCKED;
            end else begin
              state_nx = LD_ACQUIRING;
              good_nx  = GOOD_W'(1);
            end
          end
        end
        LD_ACQUIRING: begin
          if (!is_good) begin
            state_nx = LD_UNLOCKED;
            good_nx  = '0;
          end else if (good + 1'b1 == GOOD_TARGET) begin
            state_nx = LD_LOCKED;
            good_nx  = '0;
          end else begin
            good_nx  = good + 1'b1;
          end
        end
        LD_LOCKED: begin
          if (is_bad) begin
            if (UNLOCK_CYCLES == 1) begin
              state_nx = LD_UNLOCKED;
              loss     = 1'b1;
            end else begin
              state_nx = LD_SLIPPING;
              bad_nx   = BAD_W'(1);
            end
          end
        end
        LD_SLIPPING: begin
          if (!is_bad) begin
            state_nx = LD_LOCKED;
            bad_nx   = '0;
          end else if (bad + 1'b1 == BAD_TARGET) begin
            state_nx = LD_UNLOCKED;
            bad_nx   = '0;
            loss     = 1'b1;
          end else begin
            bad_nx   = bad + 1'b1;
          end
        end
        default: state_nx = LD_UNLOCKED;
      endcase
    end
  end

  always_comb begin
    lk.state_o  = state;
    lk.locked_o = (state == LD_LOCKED) || (state == LD_SLIPPING);
  end

  // A clear coincident with a sample loads the sample, so a fresh peak is never lost.
  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      lost_q   <= 1'b0;
      loss_cnt <= '0;
      peak     <= '0;
    end else begin
      lost_q <= loss;
      if (loss && (loss_cnt != '1))
        loss_cnt <= loss_cnt + 1'b1;
      if (sample) begin
        if (lk.clear_peak_i || (err_abs > peak))
          peak <= err_abs;
      end else if (lk.clear_peak_i) begin
        peak <= '0;
      end
    end
  end

  assign lk.lost_lock_o     = lost_q;
  assign lk.lock_loss_cnt_o = loss_cnt;
  assign lk.err_peak_o      = peak;
endmodule
`default_nettype wire

// File: tb/tb_adpll_lock_detector.sv
`default_nettype none
// ============================================================================
// tb_adpll_lock_detector: directed scoreboard bench for the ADPLL lock detector.
// Revision: 1.0
// ============================================================================
module tb_adpll_lock_detector;
  import adpll_pkg::*;

  logic clk;
  logic rst_n;

  adpll_lock_detector_if bus ();
  adpll_lock_detector_if #(.CNT_WIDTH(2)) bus2 ();

  adpll_lock_detector dut (
    .fpga_clk_i (clk),
    .rst_pbn_i  (rst_n),
    .lk         (bus.slave)
  );

  // Single-sample lock/loss with a 2-bit counter, so saturation is reached quickly.
  adpll_lock_detector #(
    .LOCK_CYCLES   (1),
    .UNLOCK_CYCLES (1),
    .CNT_WIDTH     (2)
  ) dut_sat (
    .fpga_clk_i (clk),
    .rst_pbn_i  (rst_n),
    .lk         (bus2.slave)
  );

  typedef struct {
    logic [1:0] st;
    logic [1:0] pre_st;
    logic       lost;
    logic [7:0] cnt;
    logic [6:0] peak;
    logic [6:0] pre_peak;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [1:0] cur_st   = LD_UNLOCKED;
  logic [6:0] exp_peak = '0;
  logic [7:0] exp_cnt  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat_abs(input int e);
    int a;
    a = (e < 0) ? -e : e;
    return (a > 127) ? 127 : a;
  endfunction

  // One ref period of four fpga_clk cycles; clr lands in the strobe cycle.
  task automatic pulse(input int err, input bit clr, input logic [1:0] st, input bit lost);
    exp_t e;
    int   a;
    e.pre_st   = cur_st;
    e.pre_peak = exp_peak;
    a = sat_abs(err);
    if (bus.enable_i && (clr || (a > int'(exp_peak))))
      exp_peak = 7'(a);
    if (lost && (exp_cnt != 8'hFF))
      exp_cnt++;
    cur_st = st;
    e.st   = st;
    e.lost = lost;
    e.cnt  = exp_cnt;
    e.peak = exp_peak;
    sb.push_back(e);
    bus.error_i   = 8'(err);
    bus.ref_clk_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.ref_clk_i    = 1'b0;
    bus.clear_peak_i = clr;
    @(negedge clk);
    bus.clear_peak_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse2(input int err, input logic [1:0] st, input bit lost, input logic [1:0] cnt);
    bus2.error_i   = 8'(err);
    bus2.ref_clk_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus2.ref_clk_i = 1'b0;
    @(posedge clk);
    #1;
    check("sat_state", bus2.state_o, st);
    check("sat_lost", bus2.lost_lock_o, lost);
    check("sat_cnt", bus2.lock_loss_cnt_o, cnt);
    @(posedge clk);
    #1;
    check("sat_lost_width", bus2.lost_lock_o, 0);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge bus.ref_clk_i);
      if (!rst_n) continue;
      repeat (2) @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: got a strobe, expected no output (t=%0t)", $time);
        continue;
      end
      e = sb[0];
      check("pre_state", bus.state_o, e.pre_st);
      check("pre_peak", bus.err_peak_o, e.pre_peak);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("state", bus.state_o, e.st);
      check("locked", bus.locked_o, e.st[1]);
      check("lost", bus.lost_lock_o, e.lost);
      check("loss_cnt", bus.lock_loss_cnt_o, e.cnt);
      check("peak", bus.err_peak_o, e.peak);
      if (e.lost) begin
        @(posedge clk);
        #1;
        check("lost_width", bus.lost_lock_o, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int cnt_tab[4];
    cnt_tab = '{1, 2, 3, 3};
    rst_n             = 1'b0;
    bus.enable_i      = 1'b1;
    bus.ref_clk_i     = 1'b0;
    bus.clear_peak_i  = 1'b0;
    bus.error_i       = -8'sd50;
    bus2.enable_i     = 1'b1;
    bus2.ref_clk_i    = 1'b0;
    bus2.clear_peak_i = 1'b0;
    bus2.error_i      = '0;

    // Reset held with ref toggling
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.ref_clk_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.ref_clk_i = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("rst_state", bus.state_o, 0);
    check("rst_locked", bus.locked_o, 0);
    check("rst_lost", bus.lost_lock_o, 0);
    check("rst_cnt", bus.lock_loss_cnt_o, 0);
    check("rst_peak", bus.err_peak_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    pulse(-50, 0, LD_UNLOCKED, 0);

    // Acquisition broken at sample 40, then a full fresh acquisition
    for (int i = 1; i <= 39; i++) pulse(3, 0, LD_ACQUIRING, 0);
    pulse(-5, 0, LD_UNLOCKED, 0);
    for (int i = 1; i <= 64; i++) pulse(3, 0, (i < 64) ? LD_ACQUIRING : LD_LOCKED, 0);

    // Hysteresis band and slip recovery
    for (int i = 0; i < 100; i++) pulse(10, 0, LD_LOCKED, 0);
    pulse(13, 0, LD_SLIPPING, 0);
    pulse(13, 0, LD_SLIPPING, 0);
    pulse(13, 0, LD_SLIPPING, 0);
    pulse(2, 0, LD_LOCKED, 0);

    // Loss event
    pulse(-20, 0, LD_SLIPPING, 0);
    pulse(-20, 0, LD_SLIPPING, 0);
    pulse(-20, 0, LD_SLIPPING, 0);
    pulse(-20, 0, LD_UNLOCKED, 1);

    // Extreme value and peak clearing
    pulse(-128, 0, LD_UNLOCKED, 0);
    pulse(6, 1, LD_UNLOCKED, 0);
    bus.clear_peak_i = 1'b1;
    @(negedge clk);
    bus.clear_peak_i = 1'b0;
    exp_peak = '0;
    check("clear_peak", bus.err_peak_o, 0);

    // Disable from LOCKED
    for (int i = 1; i <= 64; i++) pulse(3, 0, (i < 64) ? LD_ACQUIRING : LD_LOCKED, 0);
    bus.enable_i = 1'b0;
    @(negedge clk);
    cur_st = LD_UNLOCKED;
    check("dis_state", bus.state_o, LD_UNLOCKED);
    check("dis_locked", bus.locked_o, 0);
    check("dis_lost", bus.lost_lock_o, 0);
    check("dis_cnt", bus.lock_loss_cnt_o, 1);
    check("dis_peak", bus.err_peak_o, 3);
    pulse(100, 0, LD_UNLOCKED, 0);
    bus.enable_i = 1'b1;

    // Disable mid-acquisition must restart the good-sample count
    for (int i = 1; i <= 30; i++) pulse(0, 0, LD_ACQUIRING, 0);
    bus.enable_i = 1'b0;
    @(negedge clk);
    check("dis_acq_state", bus.state_o, LD_UNLOCKED);
    bus.enable_i = 1'b1;
    cur_st = LD_UNLOCKED;
    for (int i = 1; i <= 64; i++) pulse(0, 0, (i < 64) ? LD_ACQUIRING : LD_LOCKED, 0);

    // Asynchronous reset while SLIPPING
    pulse(20, 0, LD_SLIPPING, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", bus.state_o, 0);
    check("arst_locked", bus.locked_o, 0);
    check("arst_cnt", bus.lock_loss_cnt_o, 0);
    check("arst_peak", bus.err_peak_o, 0);
    cur_st   = LD_UNLOCKED;
    exp_peak = '0;
    exp_cnt  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loss-counter saturation on the single-sample instance
    for (int k = 0; k < 4; k++) begin
      pulse2(0, LD_LOCKED, 0, (k == 0) ? 2'd0 : 2'(cnt_tab[k-1]));
      pulse2(20, LD_UNLOCKED, 1, 2'(cnt_tab[k]));
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adpll_lock_detector.md
Name: adpll_lock_detector

Overview:
Consumes the signed phase-error word produced by the ring ADPLL and decides whether the loop is locked. The error is sampled once per reference-clock rising edge and two-threshold hysteresis is applied with consecutive-sample counters. The block drives a lock LED/status bit, a one-cycle loss-of-lock pulse, a saturating loss counter and a peak-|error| monitor for the seven-segment display. It sits directly downstream of the ADPLL in the top level and shares its fpga_clk domain.

Parameters:
ERR_WIDTH, 8, width of signed error_i.
LOCK_THRESH, 4, |error| <= this counts as a good sample for acquisition.
UNLOCK_THRESH, 12, |error| > this counts as a bad sample while locked. Must be >= LOCK_THRESH.
LOCK_CYCLES, 64, consecutive good samples needed to declare lock (>= 1).
UNLOCK_CYCLES, 4, consecutive bad samples needed to declare loss (>= 1).
CNT_WIDTH, 8, width of lock_loss_cnt_o.

Ports:
fpga_clk_i  in  1  system clock (258 MHz domain). Single clock.
rst_pbn_i  in  1  asynchronous, active-low reset.
enable_i  in  1  detector enable; low forces UNLOCKED.
ref_clk_i  in  1  reference clock; only its rising edge is used, as a sample strobe.
error_i  in  ERR_WIDTH  signed two's-complement phase error, fpga_clk domain.
clear_peak_i  in  1  single-cycle pulse that clears err_peak_o.
locked_o  out  1  high in LOCKED and SLIPPING.
state_o  out  2  0 UNLOCKED, 1 ACQUIRING, 2 LOCKED, 3 SLIPPING.
lost_lock_o  out  1  one-cycle pulse on the SLIPPING->UNLOCKED transition.
lock_loss_cnt_o  out  CNT_WIDTH  number of loss events, saturating at all-ones.
err_peak_o  out  ERR_WIDTH-1  maximum |error| since the last reset or clear.

Behaviour:
- Reset (asynchronous, rst_pbn_i=0):
  - state = UNLOCKED; all outputs 0.
  - good/bad counters 0; synchroniser flops 0.
- Strobe generation:
  - ref_clk_i passes through a 2-FF synchroniser (s1, s2), then a delay flop d.
  - strobe = s2 & ~d.
  - With setup met, a ref rising edge produces strobe high for exactly one cycle, two fpga_clk edges later. All state and outputs update on the following edge, i.e. the 3rd fpga_clk edge after the ref edge.
  - error_i is sampled only in the strobe cycle.
- Absolute value: |e| is computed at ERR_WIDTH-1 bits. The most-negative value (-128) saturates to 127.
- FSM, evaluated only when strobe=1 and enable_i=1:
  - UNLOCKED: if |e| <= LOCK_THRESH, go to ACQUIRING with good=1. If LOCK_CYCLES==1, go directly to LOCKED. Otherwise stay.
  - ACQUIRING:
    - |e| <= LOCK_THRESH: good+1. When good+1 == LOCK_CYCLES, go to LOCKED and clear good.
    - Otherwise go to UNLOCKED with good=0.
  - LOCKED: if |e| > UNLOCK_THRESH, go to SLIPPING with bad=1. If UNLOCK_CYCLES==1, go directly to UNLOCKED as a loss event. Otherwise stay.
  - SLIPPING:
    - |e| <= UNLOCK_THRESH: return to LOCKED with bad=0.
    - Otherwise bad+1. When bad+1 == UNLOCK_CYCLES, a loss event occurs: go to UNLOCKED, bad=0.
  - Samples between LOCK_THRESH and UNLOCK_THRESH keep LOCKED as LOCKED (this is the hysteresis band).
- Loss event, effective on the same edge as the transition:
  - lost_lock_o = 1 for exactly one fpga_clk cycle.
  - lock_loss_cnt_o increments; it holds at 2^CNT_WIDTH-1 once reached.
- enable_i = 0:
  - On the next edge: state = UNLOCKED, counters = 0, and no lost_lock_o pulse, even from LOCKED.
  - lock_loss_cnt_o and err_peak_o hold.
  - Strobes are ignored while disabled.
- Peak monitor:
  - On a strobe with enable_i=1, err_peak_o = max(err_peak_o, |e|).
  - clear_peak_i alone: err_peak_o = 0.
  - clear_peak_i coincident with a strobe: err_peak_o = |e| of that sample, i.e. the new sample wins.
- No other outputs change between strobes. locked_o and state_o are registered, not decoded combinationally from inputs.

Decomposition:
- Shared package adpll_pkg holds:
  - the state encodings LD_UNLOCKED, LD_ACQUIRING, LD_LOCKED, LD_SLIPPING;
  - default threshold constants;
  - the ERR_WIDTH default, shared with RingADPLL's error_o.
- One sub-module is natural: ref_edge_strobe, the 2-FF synchroniser plus rising-edge detector. It is reusable for any other block that samples on ref_clk.
- The FSM, counters and peak logic stay in the top module.

Test Plan:
- Reset and strobe timing: hold rst_pbn_i low with error_i=-50 and ref toggling -> all outputs 0. Release, then give one ref rising edge -> strobe seen exactly 2 edges later, outputs update on the 3rd. Check err_peak_o=50 and state_o=0.
- Acquisition: error_i=+3 for 64 ref edges -> state_o=1 after edge 1, state_o=2 and locked_o=1 after edge 64. A -5 at edge 40 instead -> state_o=0, and relock needs 64 fresh good samples.
- Hysteresis and slip recovery: when locked, error_i=10 for 100 edges -> stays LOCKED. Then 13, 13, 13, 2 -> SLIPPING for three samples, back to LOCKED, no lost_lock_o pulse.
- Loss event: when locked, error_i=-20 for 4 edges -> state UNLOCKED on the 4th. lost_lock_o high for exactly 1 fpga_clk cycle, lock_loss_cnt_o 0->1. Force 255 prior losses -> counter stays 255.
- Extreme and peak values: error_i=-128 -> err_peak_o=127. clear_peak_i in the same cycle as a strobe with error_i=6 -> err_peak_o=6. clear_peak_i alone -> 0.
- Disable and mid-operation reset: when locked, drop enable_i -> UNLOCKED next edge with no pulse, counters held. Assert rst_pbn_i mid-SLIPPING, asynchronously between clock edges -> outputs 0 immediately.
